// File: rtl/pe_phase_sequencer.sv
// rtl/pe_phase_sequencer.sv - tile phase sequencer for the PE array; optional stall counter under PE_SEQ_PERF_CNT_EN
module pe_phase_sequencer #(
   parameter int NUM_COL  = 32,
   parameter int CNT_W    = 16,
   parameter int PSUM_LAT = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_i,
   input  logic               abort_i,
   input  logic [1:0]         layer_type_i,
   input  logic               ipsum_bypass_i,
   input  logic [NUM_COL-1:0] col_mask_i,
   input  logic [CNT_W-1:0]   preheat_len_i,
   input  logic [CNT_W-1:0]   tile_len_i,
   input  logic [NUM_COL-1:0] ifmap_fifo_empty_matrix_i,
   input  logic [NUM_COL-1:0] ipsum_fifo_empty_matrix_i,
   input  logic [NUM_COL-1:0] opsum_fifo_afull_matrix_i,
   output logic [NUM_COL-1:0] ifmap_fifo_pop_matrix_o,
   output logic [NUM_COL-1:0] ipsum_fifo_pop_matrix_o,
   output logic [NUM_COL-1:0] opsum_fifo_push_matrix_o,
   output logic               preheat_state_o,
   output logic               normal_loop_state_o,
   output logic               pe_array_move_o,
   output logic               busy_o,
   output logic               done_o,
   output logic               err_o,
   output logic [31:0]        stall_cnt_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREHEAT,
      S_NORMAL,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t              r_state;
   logic [NUM_COL-1:0]  r_mask;
   logic [CNT_W-1:0]    r_pre_len;
   logic [CNT_W-1:0]    r_tile_len;
   logic [CNT_W-1:0]    r_pcnt;
   logic [CNT_W-1:0]    r_mcnt;
   logic                r_bypass;
   logic [PSUM_LAT-1:0] r_pipe;

   logic                w_ifmap_ready;
   logic                w_ipsum_ready;
   logic                w_opsum_ready;
   logic                w_pre_pop;
   logic                w_move;
   logic                w_push;
   logic                w_pre_last;
   logic                w_mv_last;
   logic                w_start_ok;
   logic                w_start_bad;
   logic [PSUM_LAT-1:0] w_pipe_shift;

   // Column readiness: only latched-mask columns can hold the array back
   assign w_ifmap_ready = ~|(ifmap_fifo_empty_matrix_i & r_mask);
   assign w_ipsum_ready = r_bypass | ~|(ipsum_fifo_empty_matrix_i & r_mask);
   assign w_opsum_ready = ~|(opsum_fifo_afull_matrix_i & r_mask);

   assign w_pre_pop = (r_state == S_PREHEAT) && (r_pre_len != '0) && w_ifmap_ready && !abort_i;
   assign w_move    = (r_state == S_NORMAL) && (r_tile_len != '0) && w_ifmap_ready
                      && w_ipsum_ready && w_opsum_ready && !abort_i;
   assign w_push    = r_pipe[PSUM_LAT-1] && !abort_i;

   assign w_pre_last   = (r_pcnt == r_pre_len - CNT_W'(1));
   assign w_mv_last    = (r_mcnt == r_tile_len - CNT_W'(1));
   assign w_pipe_shift = r_pipe << 1;

   assign w_start_ok  = (r_state == S_IDLE) && start_i && !abort_i && (layer_type_i != 2'd3);
   assign w_start_bad = (r_state == S_IDLE) && start_i && !abort_i && (layer_type_i == 2'd3);

   assign ifmap_fifo_pop_matrix_o  = (w_pre_pop || w_move) ? r_mask : '0;
   assign ipsum_fifo_pop_matrix_o  = (w_move && !r_bypass) ? r_mask : '0;
   assign opsum_fifo_push_matrix_o = w_push ? r_mask : '0;
   assign preheat_state_o          = (r_state == S_PREHEAT);
   assign normal_loop_state_o      = (r_state == S_NORMAL);
   assign pe_array_move_o          = w_move;
   assign busy_o                   = (r_state != S_IDLE);
   assign done_o                   = (r_state == S_DONE) && !abort_i;
   assign err_o                    = w_start_bad;

   // Phase FSM, tile counters and move-to-push delay pipe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_mask     <= '0;
         r_pre_len  <= '0;
         r_tile_len <= '0;
         r_pcnt     <= '0;
         r_mcnt     <= '0;
         r_bypass   <= 1'b0;
         r_pipe     <= '0;
      end else if (abort_i) begin
         r_state <= S_IDLE;
         r_pcnt  <= '0;
         r_mcnt  <= '0;
         r_pipe  <= '0;
      end else begin
         if (r_state != S_IDLE) begin
            r_pipe <= w_pipe_shift | PSUM_LAT'(w_move);
         end
         case (r_state)
            S_IDLE: begin
               if (w_start_ok) begin
                  r_mask     <= col_mask_i;
                  r_pre_len  <= preheat_len_i;
                  r_tile_len <= tile_len_i;
                  r_bypass   <= ipsum_bypass_i;
                  r_pcnt     <= '0;
                  r_mcnt     <= '0;
                  r_state    <= S_PREHEAT;
               end
            end
            S_PREHEAT: begin
               if (r_pre_len == '0) begin
                  r_state <= S_NORMAL;
               end else if (w_pre_pop) begin
                  r_pcnt <= r_pcnt + CNT_W'(1);
                  if (w_pre_last) r_state <= S_NORMAL;
               end
            end
            S_NORMAL: begin
               if (r_tile_len == '0) begin
                  r_state <= S_DRAIN;
               end else if (w_move) begin
                  r_mcnt <= r_mcnt + CNT_W'(1);
                  if (w_mv_last) r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               // Leave once the pipe empties after this cycle's shift, so
               // DONE lands right after the final push.
               if (w_pipe_shift == '0) r_state <= S_DONE;
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef PE_SEQ_PERF_CNT_EN
   logic [31:0] r_stall_cnt;

   // Count NORMAL cycles in which the array could not move; saturating
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
      end else if (w_start_ok) begin
         r_stall_cnt <= '0;
      end else if ((r_state == S_NORMAL) && !w_move && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign stall_cnt_o = r_stall_cnt;
`else
   assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_pe_phase_sequencer.sv
// tb/tb_pe_phase_sequencer.sv - scoreboard bench for pe_phase_sequencer
module tb_pe_phase_sequencer;

   localparam int NUM_COL  = 32;
   localparam int CNT_W    = 16;
   localparam int PSUM_LAT = 2;

   localparam int ST_IDLE  = 0;
   localparam int ST_PRE   = 1;
   localparam int ST_NORM  = 2;
   localparam int ST_DRAIN = 3;
   localparam int ST_DONE  = 4;

`ifdef PE_SEQ_PERF_CNT_EN
   localparam logic [31:0] EXP_STALL_T2 = 32'd3;
`else
   localparam logic [31:0] EXP_STALL_T2 = 32'd0;
`endif

   logic               clk = 1'b0;
   logic               rst_n;
   logic               start_i;
   logic               abort_i;
   logic [1:0]         layer_type_i;
   logic               ipsum_bypass_i;
   logic [NUM_COL-1:0] col_mask_i;
   logic [CNT_W-1:0]   preheat_len_i;
   logic [CNT_W-1:0]   tile_len_i;
   logic [NUM_COL-1:0] ifmap_fifo_empty_matrix_i;
   logic [NUM_COL-1:0] ipsum_fifo_empty_matrix_i;
   logic [NUM_COL-1:0] opsum_fifo_afull_matrix_i;
   logic [NUM_COL-1:0] ifmap_fifo_pop_matrix_o;
   logic [NUM_COL-1:0] ipsum_fifo_pop_matrix_o;
   logic [NUM_COL-1:0] opsum_fifo_push_matrix_o;
   logic               preheat_state_o;
   logic               normal_loop_state_o;
   logic               pe_array_move_o;
   logic               busy_o;
   logic               done_o;
   logic               err_o;
   logic [31:0]        stall_cnt_o;

   always #5 clk = ~clk;

   pe_phase_sequencer #(
      .NUM_COL (NUM_COL),
      .CNT_W   (CNT_W),
      .PSUM_LAT(PSUM_LAT)
   ) dut (
      .clk                      (clk),
      .rst_n                    (rst_n),
      .start_i                  (start_i),
      .abort_i                  (abort_i),
      .layer_type_i             (layer_type_i),
      .ipsum_bypass_i           (ipsum_bypass_i),
      .col_mask_i               (col_mask_i),
      .preheat_len_i            (preheat_len_i),
      .tile_len_i               (tile_len_i),
      .ifmap_fifo_empty_matrix_i(ifmap_fifo_empty_matrix_i),
      .ipsum_fifo_empty_matrix_i(ipsum_fifo_empty_matrix_i),
      .opsum_fifo_afull_matrix_i(opsum_fifo_afull_matrix_i),
      .ifmap_fifo_pop_matrix_o  (ifmap_fifo_pop_matrix_o),
      .ipsum_fifo_pop_matrix_o  (ipsum_fifo_pop_matrix_o),
      .opsum_fifo_push_matrix_o (opsum_fifo_push_matrix_o),
      .preheat_state_o          (preheat_state_o),
      .normal_loop_state_o      (normal_loop_state_o),
      .pe_array_move_o          (pe_array_move_o),
      .busy_o                   (busy_o),
      .done_o                   (done_o),
      .err_o                    (err_o),
      .stall_cnt_o              (stall_cnt_o)
   );

   int                 n_checks = 0;
   int                 n_pass   = 0;
   int                 cyc      = 0;
   int                 n_push_seen;
   int                 q_push[$];
   logic [NUM_COL-1:0] exp_mask;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
   endtask

   // One clock: predict this cycle's outputs, compare at negedge, advance
   task automatic tick(input int st, input bit mv, input bit ifp, input bit ipp,
                       input bit dn, input bit er, input bit ab);
      logic [NUM_COL-1:0] e_push;
      logic [5:0]         e_flags;
      if (ab) q_push.delete();
      e_push = '0;
      if (q_push.size() > 0 && q_push[0] == cyc) begin
         void'(q_push.pop_front());
         e_push = exp_mask;
      end
      if (mv) q_push.push_back(cyc + PSUM_LAT);
      e_flags = {st == ST_PRE, st == ST_NORM, mv, st != ST_IDLE, dn, er};
      @(negedge clk);
      check_val("flags", {preheat_state_o, normal_loop_state_o, pe_array_move_o,
                          busy_o, done_o, err_o}, e_flags);
      check_val("ifmap_pop", ifmap_fifo_pop_matrix_o, ifp ? exp_mask : '0);
      check_val("ipsum_pop", ipsum_fifo_pop_matrix_o, ipp ? exp_mask : '0);
      check_val("opsum_push", opsum_fifo_push_matrix_o, e_push);
      if (opsum_fifo_push_matrix_o != '0) n_push_seen++;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic fifos_ready();
      ifmap_fifo_empty_matrix_i = '0;
      ipsum_fifo_empty_matrix_i = '0;
      opsum_fifo_afull_matrix_i = '0;
   endtask

   // Drive an accepted start for one cycle (IDLE cycle checked here)
   task automatic start_tile(input logic [NUM_COL-1:0] m, input int pre, input int tl, input bit byp);
      col_mask_i     = m;
      preheat_len_i  = CNT_W'(pre);
      tile_len_i     = CNT_W'(tl);
      ipsum_bypass_i = byp;
      layer_type_i   = 2'd2;
      start_i        = 1'b1;
      exp_mask       = m;
      n_push_seen    = 0;
      tick(ST_IDLE, 0, 0, 0, 0, 0, 0);
      start_i = 1'b0;
   endtask

   // Drain, done pulse and return to IDLE after the last move
   task automatic finish_tile();
      repeat (2) tick(ST_DRAIN, 0, 0, 0, 0, 0, 0);
      tick(ST_DONE, 0, 0, 0, 1, 0, 0);
      tick(ST_IDLE, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst_n          = 1'b0;
      start_i        = 1'b0;
      abort_i        = 1'b0;
      layer_type_i   = 2'd0;
      ipsum_bypass_i = 1'b0;
      col_mask_i     = '1;
      preheat_len_i  = '0;
      tile_len_i     = '0;
      fifos_ready();
      exp_mask       = '1;
      n_push_seen    = 0;

      #12;
      check_val("rst_flags", {preheat_state_o, normal_loop_state_o, pe_array_move_o,
                              busy_o, done_o, err_o}, 0);
      check_val("rst_strobes", {ifmap_fifo_pop_matrix_o | ipsum_fifo_pop_matrix_o
                                | opsum_fifo_push_matrix_o}, 0);
      check_val("rst_stall", stall_cnt_o, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: nominal tile
      start_tile('1, 3, 4, 0);
      repeat (3) tick(ST_PRE, 0, 1, 0, 0, 0, 0);
      repeat (4) tick(ST_NORM, 1, 1, 1, 0, 0, 0);
      finish_tile();
      check_val("t1_pushes", n_push_seen, 4);
      check_val("t1_stall", stall_cnt_o, 0);

      // 2: ipsum column 5 empty for 3 cycles mid-NORMAL
      start_tile('1, 3, 4, 0);
      repeat (3) tick(ST_PRE, 0, 1, 0, 0, 0, 0);
      repeat (2) tick(ST_NORM, 1, 1, 1, 0, 0, 0);
      ipsum_fifo_empty_matrix_i[5] = 1'b1;
      repeat (3) tick(ST_NORM, 0, 0, 0, 0, 0, 0);
      ipsum_fifo_empty_matrix_i[5] = 1'b0;
      repeat (2) tick(ST_NORM, 1, 1, 1, 0, 0, 0);
      finish_tile();
      check_val("t2_pushes", n_push_seen, 4);
      check_val("t2_stall", stall_cnt_o, EXP_STALL_T2);

      // 3: bypass with every ipsum FIFO empty
      ipsum_fifo_empty_matrix_i = '1;
      start_tile('1, 1, 2, 1);
      tick(ST_PRE, 0, 1, 0, 0, 0, 0);
      repeat (2) tick(ST_NORM, 1, 1, 0, 0, 0, 0);
      finish_tile();
      check_val("t3_pushes", n_push_seen, 2);
      fifos_ready();

      // 4: unmasked empty column ignored; mask latched at start
      ifmap_fifo_empty_matrix_i[20] = 1'b1;
      start_tile(32'h0000_00FF, 2, 2, 0);
      col_mask_i = '1;
      repeat (2) tick(ST_PRE, 0, 1, 0, 0, 0, 0);
      repeat (2) tick(ST_NORM, 1, 1, 1, 0, 0, 0);
      finish_tile();
      check_val("t4_pushes", n_push_seen, 2);
      fifos_ready();

      // 5: reserved layer type rejected; abort beats start; zero-length tile
      layer_type_i = 2'd3;
      start_i      = 1'b1;
      tick(ST_IDLE, 0, 0, 0, 0, 1, 0);
      start_i      = 1'b0;
      tick(ST_IDLE, 0, 0, 0, 0, 0, 0);
      layer_type_i = 2'd0;
      start_i      = 1'b1;
      abort_i      = 1'b1;
      tick(ST_IDLE, 0, 0, 0, 0, 0, 1);
      start_i      = 1'b0;
      abort_i      = 1'b0;
      tick(ST_IDLE, 0, 0, 0, 0, 0, 0);
      start_tile('1, 0, 0, 0);
      tick(ST_PRE, 0, 0, 0, 0, 0, 0);
      tick(ST_NORM, 0, 0, 0, 0, 0, 0);
      tick(ST_DRAIN, 0, 0, 0, 0, 0, 0);
      tick(ST_DONE, 0, 0, 0, 1, 0, 0);
      tick(ST_IDLE, 0, 0, 0, 0, 0, 0);
      check_val("t5_pushes", n_push_seen, 0);

      // 6: abort after 2 of 5 moves with pushes pending, then a clean tile
      start_tile('1, 1, 5, 0);
      tick(ST_PRE, 0, 1, 0, 0, 0, 0);
      repeat (2) tick(ST_NORM, 1, 1, 1, 0, 0, 0);
      abort_i = 1'b1;
      tick(ST_NORM, 0, 0, 0, 0, 0, 1);
      abort_i = 1'b0;
      repeat (3) tick(ST_IDLE, 0, 0, 0, 0, 0, 0);
      check_val("t6_abort_pushes", n_push_seen, 0);
      start_tile('1, 1, 5, 0);
      tick(ST_PRE, 0, 1, 0, 0, 0, 0);
      repeat (5) tick(ST_NORM, 1, 1, 1, 0, 0, 0);
      finish_tile();
      check_val("t6_pushes", n_push_seen, 5);

      // 7: asynchronous reset mid-NORMAL drops everything at once
      start_tile('1, 1, 4, 0);
      tick(ST_PRE, 0, 1, 0, 0, 0, 0);
      tick(ST_NORM, 1, 1, 1, 0, 0, 0);
      check_val("t7_pre_rst_move", pe_array_move_o, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("t7_rst_busy", busy_o, 0);
      check_val("t7_rst_strobes", {ifmap_fifo_pop_matrix_o | ipsum_fifo_pop_matrix_o
                                   | opsum_fifo_push_matrix_o}, 0);
      check_val("t7_rst_move", pe_array_move_o, 0);
      q_push.delete();
      #5;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      tick(ST_IDLE, 0, 0, 0, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pe_phase_sequencer.md
Name: pe_phase_sequencer

Overview:
- Phase-level controller for the 32x32 PE array in the token engine.
- Sequences one tile IDLE -> PREHEAT -> NORMAL -> DRAIN -> DONE.
- Produces the preheat/normal-loop state flags and the array move strobe consumed by the PE array stall/enable logic.
- Gates ifmap/ipsum FIFO pops and opsum FIFO pushes from per-column FIFO status so the array only advances when every enabled column can move.

Parameters:
NUM_COL, 32, number of PE columns / FIFO lanes
CNT_W, 16, width of preheat and move counters
PSUM_LAT, 2, cycles from a move to the matching opsum push (1..8)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start_i  in  1  start one tile; sampled in IDLE only
abort_i  in  1  synchronous abort, any state
layer_type_i  in  2  0=pointwise, 1=depthwise, 2=standard, 3=reserved
ipsum_bypass_i  in  1  1 = first channel tile; no ipsum consumed
col_mask_i  in  NUM_COL  enabled columns, latched at start
preheat_len_i  in  CNT_W  ifmap pops before the normal loop
tile_len_i  in  CNT_W  array moves in the normal loop
ifmap_fifo_empty_matrix_i  in  NUM_COL  per-column empty
ipsum_fifo_empty_matrix_i  in  NUM_COL  per-column empty
opsum_fifo_afull_matrix_i  in  NUM_COL  per-column almost-full, at least PSUM_LAT+1 free entries left when deasserted
ifmap_fifo_pop_matrix_o  out  NUM_COL  ifmap pop strobes
ipsum_fifo_pop_matrix_o  out  NUM_COL  ipsum pop strobes
opsum_fifo_push_matrix_o  out  NUM_COL  opsum push strobes
preheat_state_o  out  1  state == PREHEAT
normal_loop_state_o  out  1  state == NORMAL
pe_array_move_o  out  1  array advances this cycle
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle pulse at tile end
err_o  out  1  one-cycle pulse on rejected start
stall_cnt_o  out  32  see Optional Feature

Behaviour:
- Reset: state=IDLE; counters, delay pipe and every output = 0.
- State flags, busy_o and all strobes are combinational from registered state, counters and current inputs.
- Only masked columns (latched mask M) are checked or strobed; unmasked bits are always 0.
- IDLE:
  - start_i with layer_type_i!=3: latch M, lengths, bypass and layer type; go to PREHEAT.
  - start_i with layer_type_i==3: pulse err_o, stay in IDLE.
  - start_i while busy is ignored.
- PREHEAT:
  - pop_ok = no masked ifmap FIFO empty.
  - When pop_ok: ifmap_pop = M and pcnt++.
  - Go to NORMAL on a pop with pcnt==preheat_len-1.
  - preheat_len==0: go to NORMAL the cycle after entry, no pops.
  - No move and no ipsum pop in this state.
- NORMAL:
  - move = no masked ifmap empty AND (bypass OR no masked ipsum empty) AND no masked opsum afull.
  - pe_array_move_o=move.
  - On move: ifmap_pop=M; ipsum_pop=M unless bypass; mcnt++; set delay-pipe stage 0.
  - Go to DRAIN on a move with mcnt==tile_len-1.
  - tile_len==0: go to DRAIN immediately.
- Delay pipe: PSUM_LAT-stage shift register, advances every cycle in any state except IDLE. opsum_push = M when the last stage is set. A push therefore occurs exactly PSUM_LAT cycles after its move.
- DRAIN: no moves or pops; go to DONE when the pipe is all zero.
- DONE: done_o=1 for one cycle, then IDLE. Total pushes = tile_len.
- abort_i:
  - Has priority over every transition.
  - Next state IDLE, pipe cleared, counters cleared.
  - No done_o; strobes in the abort cycle are suppressed.
- Simultaneous abort_i and start_i in IDLE: abort wins; start is ignored.
- Async reset mid-tile returns to IDLE immediately and drops all strobes.
- Counters never wrap; transitions compare with ==, and lengths are held constant for the tile.

Optional Feature:
- Macro PE_SEQ_PERF_CNT_EN.
- Defined:
  - stall_cnt_o counts NORMAL cycles with move==0, saturating at 2^32-1.
  - Cleared on reset and on each accepted start.
  - Holds its value in IDLE.
- Undefined: stall_cnt_o tied to 0 and no counter logic.

Test Plan:
1. M=32'hFFFF_FFFF, preheat_len=3, tile_len=4, all FIFOs ready, bypass=0, PSUM_LAT=2 -> 3 ifmap pops, 4 moves on consecutive cycles, pushes in move cycles +2, done_o 1 cycle after the last push, 4 pushes total.
2. Same setup, but ipsum column 5 empty for 3 cycles mid-NORMAL -> move low for 3 cycles and no pops; moves resume; PERF_CNT_EN stall_cnt_o=3.
3. bypass=1, ipsum all empty, tile_len=2 -> 2 moves, ipsum_pop stays 0.
4. M=32'h0000_00FF, column 20 ifmap empty -> no effect; pops equal 32'h0000_00FF.
5. start_i with layer_type_i=3 -> err_o pulse, busy_o stays 0; preheat_len=0, tile_len=0 -> PREHEAT, NORMAL, DRAIN, DONE with zero pops, done_o pulses.
6. abort_i in NORMAL after 2 of 5 moves, with a push pending -> next cycle IDLE, no further push, no done_o; a fresh start then runs the full tile.
